// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the ALU arbiter slice.
//   WIDTH         default operand/result width (only 32 is supported)
//   OP_*          ALU opcodes 0..5 (6 and 7 produce zero)
//   state_e       arbiter FSM encoding S_IDLE / S_EXEC / S_RESP
//   add_sub_ovf   signed-overflow rule for add/sub, zero for other opcodes
package alu_ctrl_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Add overflows when both operands share a sign the result lacks; subtract
  // overflows when the operand signs differ and the result leaves a's sign.
  function automatic logic add_sub_ovf(input logic [2:0] f, input logic a_msb,
                                       input logic b_msb, input logic y_msb);
    logic ovf;
    case (f)
      OP_ADD:  ovf = (a_msb == b_msb) && (y_msb != a_msb);
      OP_SUB:  ovf = (a_msb != b_msb) && (y_msb != a_msb);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational WIDTH-bit ALU.
//   a_i, b_i  operands
//   f_i       opcode (see alu_ctrl_pkg)
//   y_o       result; 6 and 7 give zero, SLT gives 1/0 (unsigned compare)
//   ovf_o     signed overflow for add/sub, 0 otherwise
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = alu_ctrl_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       f_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  // Result select by opcode; wraps modulo 2^WIDTH.
  always_comb begin
    y_o = '0;
    case (f_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_NOT:  y_o = ~a_i;
      OP_SLT:  y_o = (a_i < b_i) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: y_o = '0;
    endcase
  end

  assign ovf_o = add_sub_ovf(f_i, a_i[WIDTH-1], b_i[WIDTH-1], y_o[WIDTH-1]);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters.
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/f        requester N operation handshake (N = 0, 1)
//   rsp_valid/ready               response handshake
//   rsp_id, rsp_y, rsp_ovf        issuing requester, result, signed overflow
// Round-robin arbitration in IDLE, operands registered, result captured in
// EXEC, held in RESP until taken. One operation per three cycles at best.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = alu_ctrl_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_ovf
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       f_q, f_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             rsp_id_q, rsp_id_d;

  logic             win_s;
  logic             any_valid_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_ovf_unused_s;
  logic             ovf_s;

  // The alu's own overflow output is deliberately ignored; the flag is
  // derived here from the registered operands.
  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .f_i   (f_q),
    .y_o   (alu_y_s),
    .ovf_o (alu_ovf_unused_s)
  );

  assign ovf_s       = add_sub_ovf(f_q, a_q[WIDTH-1], b_q[WIDTH-1], alu_y_s[WIDTH-1]);
  assign any_valid_s = req0_valid | req1_valid;

  // Round-robin winner: on a tie the requester not granted last time wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      win_s = ~last_grant_q;
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state, operand/result capture and combinational ready outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    f_d          = f_q;
    id_d         = id_q;
    y_d          = y_q;
    ovf_d        = ovf_q;
    rsp_id_d     = rsp_id_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid_s) begin
          req0_ready   = ~win_s;
          req1_ready   = win_s;
          a_d          = win_s ? req1_a : req0_a;
          b_d          = win_s ? req1_b : req0_b;
          f_d          = win_s ? req1_f : req0_f;
          id_d         = win_s;
          last_grant_d = win_s;
          state_d      = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        y_d      = alu_y_s;
        ovf_d    = ovf_s;
        rsp_id_d = id_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, tie pointer, operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      f_q          <= 3'd0;
      id_q         <= 1'b0;
      y_q          <= '0;
      ovf_q        <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      f_q          <= f_d;
      id_q         <= id_d;
      y_q          <= y_d;
      ovf_q        <= ovf_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = y_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [2:0]  req0_f = 3'd0, req1_f = 3'd0;
  logic        rsp_valid, rsp_id, rsp_ovf;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_y;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] y;
    logic        ovf;
    logic        id;
  } rsp_t;

  // Exact signed arithmetic: overflow when the wrapped result differs from the true value.
  function automatic rsp_t ref_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    rsp_t   r;
    longint sa, sb, exact, wrapped;
    sa = $signed(a);
    sb = $signed(b);
    r.id = id;
    r.ovf = 1'b0;
    case (f)
      3'd0: begin exact = sa + sb; r.y = a + b; wrapped = $signed(r.y); r.ovf = (exact != wrapped); end
      3'd1: begin exact = sa - sb; r.y = a - b; wrapped = $signed(r.y); r.ovf = (exact != wrapped); end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = ~a;
      3'd5: r.y = (a < b) ? 32'd1 : 32'd0;
      default: r.y = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] arb(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  logic busy_m = 1'b0;   // an operation is in flight
  int   wait_m = 0;      // cycles until its response becomes visible
  logic last_m = 1'b1;   // requester granted most recently
  rsp_t exp_m;
  logic acc0 = 1'b0, acc1 = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [1:0] g;
    if (rst) begin
      busy_m = 1'b0; wait_m = 0; last_m = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      acc0 = 1'b0; acc1 = 1'b0;
      if (busy_m) begin
        if (wait_m > 0) wait_m--;
        else if (rsp_ready) busy_m = 1'b0;
      end else begin
        g = arb(req0_valid, req1_valid, last_m);
        if (g[0]) begin exp_m = ref_op(1'b0, req0_a, req0_b, req0_f); acc0 = 1'b1; end
        if (g[1]) begin exp_m = ref_op(1'b1, req1_a, req1_b, req1_f); acc1 = 1'b1; end
        if (g != 2'b00) begin busy_m = 1'b1; wait_m = 1; last_m = g[1]; end
      end
    end
  end

  // Single compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic [1:0] g;
    logic       ev;
    g  = busy_m ? 2'b00 : arb(req0_valid, req1_valid, last_m);
    ev = busy_m && (wait_m == 0);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g[0]});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g[1]});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    if (ev) begin
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_m.id});
      chk("rsp_y", rsp_y, exp_m.y);
      chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_m.ovf});
    end
    if (rst) begin
      chk("rst_y", rsp_y, 32'd0);
      chk("rst_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_ovf", {31'd0, rsp_ovf}, 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_f = f; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; req0_f = f; end
  endtask

  // Wait (bounded) at negedges until the given requester sees ready.
  task automatic wait_ready(input logic id, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_handshake"}, {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
  endtask

  // One isolated operation with hand-computed expectations and latency check.
  task automatic do_op(input string nm, input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [31:0] ey, input logic eovf);
    @(posedge clk); #1;
    set_req(id, 1'b1, a, b, f);
    wait_ready(id, nm);
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, f);
    @(negedge clk);
    chk({nm, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_y"}, rsp_y, ey);
    chk({nm, "_ovf"}, {31'd0, rsp_ovf}, {31'd0, eovf});
    chk({nm, "_id"}, {31'd0, rsp_id}, {31'd0, id});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic        rid [4];
    logic [31:0] ry  [4];
    logic [31:0] snap_y;
    logic        snap_id, snap_ovf;
    int          k, n;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_y", rsp_y, 32'd0);
    chk("reset_r0", {31'd0, req0_ready}, 32'd0);
    chk("reset_r1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Arbitration from reset: both valid continuously.
    set_req(1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 3'd2);
    set_req(1'b1, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 3'd3);
    k = 0; n = 0;
    while (k < 4 && n < 60) begin
      @(negedge clk); n++;
      if (rsp_valid) begin rid[k] = rsp_id; ry[k] = rsp_y; k++; end
    end
    chk("arb_count", k, 32'd4);
    for (int i = 0; i < k; i++) begin
      chk("arb_id", {31'd0, rid[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("arb_y", ry[i], (i % 2 == 0) ? 32'h0000_F000 : 32'h0000_FFF0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(posedge clk);

    // Add / subtract / remaining opcodes.
    do_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 1'b1);
    do_op("sub", 1'b1, 32'd5, 32'd7, 3'd1, 32'hFFFF_FFFE, 1'b0);
    do_op("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 3'd1, 32'h7FFF_FFFF, 1'b1);
    do_op("slt", 1'b0, 32'd1, 32'hFFFF_FFFF, 3'd5, 32'd1, 1'b0);
    do_op("not", 1'b1, 32'd0, 32'h1234_5678, 3'd4, 32'hFFFF_FFFF, 1'b0);
    do_op("f6", 1'b0, 32'h7FFF_FFFF, 32'd1, 3'd6, 32'd0, 1'b0);
    do_op("f7", 1'b1, 32'h7FFF_FFFF, 32'd1, 3'd7, 32'd0, 1'b0);

    // Backpressure: response held for 10 cycles with both requesters waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'd3, 32'd4, 3'd0);
    wait_ready(1'b0, "bp");
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'd9, 32'd9, 3'd1);
    set_req(1'b1, 1'b1, 32'd6, 32'd2, 3'd2);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_y", rsp_y, 32'd7);
    snap_y = rsp_y; snap_id = rsp_id; snap_ovf = rsp_ovf;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_y", rsp_y, snap_y);
      chk("bp_hold_id", {31'd0, rsp_id}, {31'd0, snap_id});
      chk("bp_hold_ovf", {31'd0, rsp_ovf}, {31'd0, snap_ovf});
      chk("bp_hold_r0", {31'd0, req0_ready}, 32'd0);
      chk("bp_hold_r1", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_r1", {31'd0, req1_ready}, 32'd1);
    chk("bp_release_r0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (5) @(posedge clk);

    // Reset during EXEC: req0 wins first so the tie pointer points at 0.
    #1;
    set_req(1'b0, 1'b1, 32'd10, 32'd20, 3'd0);
    wait_ready(1'b0, "mid_rst");
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_y", rsp_y, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1'b0, 1'b1, 32'd2, 32'd3, 3'd0);
    set_req(1'b1, 1'b1, 32'd1, 32'd2, 3'd3);
    n = 0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("post_rst_seen", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    chk("post_rst_y", rsp_y, 32'd5);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(posedge clk);

    // Randomized traffic; requests are held until accepted, sometimes withdrawn.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid) begin
        if ($urandom_range(0, 2) == 0)
          set_req(1'b0, 1'b1, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)));
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid) begin
        if ($urandom_range(0, 2) == 0)
          set_req(1'b1, 1'b1, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)));
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
